// File: rtl/sys_array_loader.sv
// ----------------------------------------------------------------------------
// sys_array_loader : streams matrix A then W into packed row-major buses and
//                    sequences the systolic-array fetcher (params, start, wait).
// Revision         : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sys_array_loader #(
  parameter int DATA_WIDTH = 8,
  parameter int ARRAY_A_W  = 4,
  parameter int ARRAY_A_L  = 3,
  parameter int ARRAY_W_W  = 3,
  parameter int ARRAY_W_L  = 4
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     load_req,
  input  logic                                     s_valid,
  output logic                                     s_ready,
  input  logic [DATA_WIDTH-1:0]                    s_data,
  input  logic                                     s_last,
  output logic [ARRAY_A_W*ARRAY_A_L*DATA_WIDTH-1:0] data_a,
  output logic [ARRAY_W_W*ARRAY_W_L*DATA_WIDTH-1:0] data_w,
  output logic                                     load_params,
  output logic                                     start_comp,
  input  logic                                     comp_ready,
  output logic                                     busy,
  output logic                                     done,
  output logic                                     frame_err
);

  localparam int NUM_A   = ARRAY_A_W * ARRAY_A_L;
  localparam int NUM_W   = ARRAY_W_W * ARRAY_W_L;
  localparam int NUM_MAX = (NUM_A > NUM_W) ? NUM_A : NUM_W;
  localparam int CNT_W   = $clog2(NUM_MAX) + 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_A = 3'd1,
    S_LOAD_W = 3'd2,
    S_PARAM  = 3'd3,
    S_START  = 3'd4,
    S_WAIT   = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  state_t                        state_q, state_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic [NUM_A*DATA_WIDTH-1:0]   data_a_q, data_a_d;
  logic [NUM_W*DATA_WIDTH-1:0]   data_w_q, data_w_d;
  logic                          frame_err_q, frame_err_d;
  logic                          xfer;
  logic                          last_w;

  // Handshake outputs decode the state register only, never the inputs.
  assign s_ready     = (state_q == S_LOAD_A) || (state_q == S_LOAD_W);
  assign load_params = (state_q == S_PARAM);
  assign start_comp  = (state_q == S_START);
  assign busy        = (state_q == S_LOAD_A) || (state_q == S_LOAD_W) ||
                       (state_q == S_PARAM)  || (state_q == S_START)  ||
                       (state_q == S_WAIT);
  assign done        = (state_q == S_DONE);
  assign frame_err   = frame_err_q;
  assign data_a      = data_a_q;
  assign data_w      = data_w_q;

  assign xfer   = s_valid && s_ready;
  assign last_w = (cnt_q == CNT_W'(NUM_W - 1));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    data_a_d    = data_a_q;
    data_w_d    = data_w_q;
    frame_err_d = frame_err_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (load_req) begin
          state_d     = S_LOAD_A;
          cnt_d       = '0;
          frame_err_d = 1'b0;
        end
      end

      S_LOAD_A: begin
        if (xfer) begin
          // Element k of the stream lands at slot k counted from the MSB end.
          for (int k = 0; k < NUM_A; k++) begin
            if (cnt_q == CNT_W'(k)) begin
              data_a_d[(NUM_A-k)*DATA_WIDTH-1 -: DATA_WIDTH] = s_data;
            end
          end
          if (s_last) begin
            frame_err_d = 1'b1;
            state_d     = S_IDLE;
            cnt_d       = '0;
          end else if (cnt_q == CNT_W'(NUM_A - 1)) begin
            state_d = S_LOAD_W;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      S_LOAD_W: begin
        if (xfer) begin
          for (int k = 0; k < NUM_W; k++) begin
            if (cnt_q == CNT_W'(k)) begin
              data_w_d[(NUM_W-k)*DATA_WIDTH-1 -: DATA_WIDTH] = s_data;
            end
          end
          if (s_last != last_w) begin
            frame_err_d = 1'b1;
            state_d     = S_IDLE;
            cnt_d       = '0;
          end else if (last_w) begin
            state_d = S_PARAM;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      S_PARAM: state_d = S_START;
      S_START: state_d = S_WAIT;

      S_WAIT: begin
        if (comp_ready) begin
          state_d = S_DONE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      data_a_q    <= '0;
      data_w_q    <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      data_a_q    <= data_a_d;
      data_w_q    <= data_w_d;
      frame_err_q <= frame_err_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sys_array_loader.sv
// ----------------------------------------------------------------------------
// tb_sys_array_loader : directed table-driven bench for sys_array_loader.
// Revision            : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_sys_array_loader;

  logic        clk;
  logic        reset;
  logic        load_req;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_data;
  logic        s_last;
  logic [95:0] data_a;
  logic [95:0] data_w;
  logic        load_params;
  logic        start_comp;
  logic        comp_ready;
  logic        busy;
  logic        done;
  logic        frame_err;

  int n_chk  = 0;
  int n_fail = 0;

  sys_array_loader #(
    .DATA_WIDTH(8), .ARRAY_A_W(4), .ARRAY_A_L(3), .ARRAY_W_W(3), .ARRAY_W_L(4)
  ) dut (
    .clk(clk), .reset(reset), .load_req(load_req),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .data_a(data_a), .data_w(data_w),
    .load_params(load_params), .start_comp(start_comp), .comp_ready(comp_ready),
    .busy(busy), .done(done), .frame_err(frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle-level vector: inputs applied before an edge, flags expected after.
  // exp = {s_ready, busy, load_params, start_comp, done, frame_err}
  typedef struct {
    logic       lreq;
    logic       vld;
    logic [7:0] dat;
    logic       last;
    logic       crdy;
    logic [5:0] exp;
  } vec_t;

  vec_t tbl [38];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic last);
    int n;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    n = 0;
    while (!s_ready && n < 20) begin
      tick();
      n++;
    end
    if (!s_ready) chk("send_timeout", {95'd0, s_ready}, 96'd1);
    tick();
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    load_req   = 1'b0;
    s_valid    = 1'b0;
    s_data     = '0;
    s_last     = 1'b0;
    comp_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic start_load();
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
  endtask

  function automatic logic [5:0] flags();
    return {s_ready, busy, load_params, start_comp, done, frame_err};
  endfunction

  logic [95:0] exp_a, exp_w, exp_r;
  logic        seen_a, seen_b;

  initial begin
    // Nominal load table: A=1..12, W=13..24, s_last on 24, 10 idle WAIT cycles.
    for (int i = 0; i < 38; i++) begin
      tbl[i].lreq = 1'b0; tbl[i].vld = 1'b0; tbl[i].dat = 8'd0;
      tbl[i].last = 1'b0; tbl[i].crdy = 1'b0; tbl[i].exp = 6'b010000;
    end
    tbl[0].lreq = 1'b1;
    tbl[0].exp  = 6'b110000;
    for (int i = 1; i <= 24; i++) begin
      tbl[i].vld  = 1'b1;
      tbl[i].dat  = 8'(i);
      tbl[i].last = (i == 24);
      tbl[i].exp  = (i == 24) ? 6'b011000 : 6'b110000;
    end
    tbl[25].exp  = 6'b010100;
    tbl[36].crdy = 1'b1;
    tbl[36].exp  = 6'b000010;
    tbl[37].exp  = 6'b000010;

    exp_a = '0;
    exp_w = '0;
    for (int k = 0; k < 12; k++) exp_a = {exp_a[87:0], 8'(k + 1)};
    for (int k = 0; k < 12; k++) exp_w = {exp_w[87:0], 8'(k + 13)};

    do_reset();
    chk("reset_flags", {90'd0, flags()}, 96'd0);
    chk("reset_data_a", data_a, 96'd0);
    chk("reset_data_w", data_w, 96'd0);

    for (int i = 0; i < 38; i++) begin
      load_req   = tbl[i].lreq;
      s_valid    = tbl[i].vld;
      s_data     = tbl[i].dat;
      s_last     = tbl[i].last;
      comp_ready = tbl[i].crdy;
      tick();
      chk($sformatf("nom_vec%0d", i), {90'd0, flags()}, {90'd0, tbl[i].exp});
    end
    comp_ready = 1'b0;
    chk("nom_a_first", {88'd0, data_a[95:88]}, 96'd1);
    chk("nom_a_last", {88'd0, data_a[7:0]}, 96'd12);
    chk("nom_w_first", {88'd0, data_w[95:88]}, 96'd13);
    chk("nom_w_last", {88'd0, data_w[7:0]}, 96'd24);
    chk("nom_data_a", data_a, exp_a);
    chk("nom_data_w", data_w, exp_w);

    // Back-pressure: idle cycle between every element.
    do_reset();
    start_load();
    for (int k = 1; k <= 24; k++) begin
      send(8'(k), k == 24);
      if (k < 24) begin
        s_valid = 1'b0;
        s_last  = 1'b0;
        tick();
        chk($sformatf("bp_ready%0d", k), {95'd0, s_ready}, 96'd1);
      end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    chk("bp_load_params", {95'd0, load_params}, 96'd1);
    tick();
    chk("bp_start_comp", {95'd0, start_comp}, 96'd1);
    chk("bp_data_a", data_a, exp_a);
    chk("bp_data_w", data_w, exp_w);
    comp_ready = 1'b1;
    tick();
    tick();
    comp_ready = 1'b0;
    chk("bp_done_flags", {90'd0, flags()}, {90'd0, 6'b000010});

    // Reload from DONE with A all 0xFF.
    start_load();
    chk("rl_flags", {90'd0, flags()}, {90'd0, 6'b110000});
    send(8'hFF, 1'b0);
    exp_r = exp_a;
    exp_r[95:88] = 8'hFF;
    chk("rl_partial_a", data_a, exp_r);
    chk("rl_w_held", data_w, exp_w);
    for (int k = 1; k < 12; k++) send(8'hFF, 1'b0);
    chk("rl_all_ff", data_a, {96{1'b1}});
    for (int k = 13; k <= 24; k++) send(8'(k), k == 24);
    s_valid = 1'b0;
    s_last  = 1'b0;
    chk("rl_load_params", {95'd0, load_params}, 96'd1);
    tick();
    chk("rl_start_comp", {95'd0, start_comp}, 96'd1);
    comp_ready = 1'b1;
    tick();
    tick();
    comp_ready = 1'b0;
    chk("rl_done", {95'd0, done}, 96'd1);

    // Early s_last on A element 5.
    do_reset();
    start_load();
    for (int k = 1; k <= 4; k++) send(8'(k), 1'b0);
    send(8'd5, 1'b1);
    s_valid = 1'b0;
    s_last  = 1'b0;
    chk("es_flags", {90'd0, flags()}, {90'd0, 6'b000001});
    exp_r = '0;
    for (int k = 1; k <= 5; k++) exp_r = {exp_r[87:0], 8'(k)};
    exp_r = exp_r << 56;
    chk("es_partial_a", data_a, exp_r);
    seen_a = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      seen_a |= load_params;
    end
    chk("es_no_params", {95'd0, seen_a}, 96'd0);
    start_load();
    chk("es_clear", {90'd0, flags()}, {90'd0, 6'b110000});

    // Missing s_last on the final W element.
    for (int k = 1; k <= 24; k++) send(8'(k), 1'b0);
    s_valid = 1'b0;
    chk("ms_flags", {90'd0, flags()}, {90'd0, 6'b000001});
    seen_a = 1'b0;
    seen_b = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      seen_a |= start_comp;
      seen_b |= done;
    end
    chk("ms_no_start", {95'd0, seen_a}, 96'd0);
    chk("ms_no_done", {95'd0, seen_b}, 96'd0);

    // Asynchronous reset while waiting for comp_ready.
    start_load();
    for (int k = 1; k <= 24; k++) send(8'(k), k == 24);
    s_valid = 1'b0;
    s_last  = 1'b0;
    tick();
    tick();
    chk("ar_wait_flags", {90'd0, flags()}, {90'd0, 6'b010000});
    #3;
    reset = 1'b1;
    #1;
    chk("ar_flags", {90'd0, flags()}, 96'd0);
    chk("ar_data_a", data_a, 96'd0);
    chk("ar_data_w", data_w, 96'd0);
    tick();
    reset = 1'b0;
    tick();
    chk("ar_idle", {90'd0, flags()}, 96'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
